serial_rx: RTL and testbench
============================

Name: serial_rx

Overview:
Receiver for the team's single-wire serial frame protocol: idle-high line, one start bit (0), DATA_WIDTH data bits LSB first, one stop bit (1), one bit per clock.
- Deserialises each frame and checks the stop bit.
- Presents the word on a valid/ready output port.
- Sits at the far end of the link from the serial transmitter and feeds downstream consumers.

Parameters:
DATA_WIDTH, 4, data bits per frame; must match the transmitter. Legal range 2..16.

Ports:
clk  input  1  system clock; all state updates on posedge
rst  input  1  asynchronous active-high reset
serial_in  input  1  serial line; idle level 1
data_out  output  DATA_WIDTH  received word; stable while valid_out=1
valid_out  output  1  data_out holds an unconsumed word
ready_in  input  1  consumer accepts data_out when valid_out && ready_in
busy_out  output  1  frame reception in progress (state != S_IDLE)
frame_err  output  1  one-cycle pulse: stop bit sampled as 0
overrun_err  output  1  one-cycle pulse: good frame dropped because the output register was full

Behaviour:
- Reset (async assert, sync release):
  - state=S_IDLE, shift register=0, bit counter=0.
  - data_out=0, valid_out=0, busy_out=0, frame_err=0, overrun_err=0.
  - Reset mid-frame aborts the frame silently; no error pulse.
- Sampling: serial_in sampled once per posedge; no oversampling.
- State S_IDLE:
  - serial_in=0 -> S_DATA, bit counter cleared.
  - serial_in=1 -> stay.
- State S_DATA:
  - Shift serial_in into the shift-register MSB, shifting right, so the first data bit ends up in bit 0.
  - Bit counter increments each cycle (width clog2(DATA_WIDTH)).
  - Counter == DATA_WIDTH-1 in this cycle -> S_STOP.
- State S_STOP:
  - serial_in=1 (good frame) -> S_IDLE and deliver the word.
  - serial_in=0 -> frame_err pulses next cycle; word discarded; -> S_RECOVER.
- State S_RECOVER: wait for serial_in=1, then -> S_IDLE. A held-low line must not be taken as a new start bit.
- Delivery and output register, from the edge that samples a good stop bit:
  - valid_out=0, or valid_out=1 with ready_in=1 in that cycle: load data_out; valid_out=1.
  - valid_out=1 with ready_in=0: keep the old word; overrun_err pulses for 1 cycle.
- Handshake:
  - valid_out drops on the edge where valid_out && ready_in, unless a new word loads on the same edge; a simultaneous load wins and valid_out stays 1.
  - ready_in is ignored while valid_out=0.
- Latency:
  - Start bit sampled at edge T0; data bits at T0+1..T0+DATA_WIDTH; stop bit at T0+DATA_WIDTH+1.
  - valid_out is high after edge T0+DATA_WIDTH+1.
- Back-to-back frames: a start bit sampled on the edge immediately after the stop bit is accepted. S_IDLE lasts a minimum of one cycle.
- busy_out is registered alongside state: high in S_DATA, S_STOP and S_RECOVER; low in S_IDLE.
- frame_err and overrun_err never stay high for 2 consecutive cycles from a single event.

Optional Feature:
Macro SERIAL_RX_SYNC_EN.
- Defined: serial_in passes through a 2-flop synchroniser before the FSM.
  - Synchroniser flops reset to 1 (idle level).
  - All latencies above grow by 2 cycles.
- Undefined: serial_in feeds the FSM directly; the line must be synchronous to clk.

Decomposition:
- Package serial_pkg holds:
  - rx_state_t enum, logic[1:0]: S_IDLE, S_DATA, S_STOP, S_RECOVER.
  - Constants SERIAL_IDLE_LVL=1'b1, SERIAL_START_LVL=1'b0, SERIAL_STOP_LVL=1'b1.
  - SERIAL_DATA_W_DEF=4.
- One sub-module: serial_sync2, the 2-flop synchroniser with async reset to 1, instantiated only under SERIAL_RX_SYNC_EN.

Test Plan:
- Good frame: after reset with ready_in=1, drive line 1,0,0,1,0,1,1 (start, data 0,1,0,1, stop) -> one cycle after the stop edge, valid_out=1, data_out=4'hA; valid_out drops the next cycle.
- Back-to-back: send 4'h3 then 4'hC with no idle gap between the stop bit and the next start bit -> two deliveries, 3 then C, 6 cycles apart.
- Framing error: send start, data 4'h5, stop=0, hold the line low 3 more cycles, then 1 -> frame_err pulses once, valid_out stays 0, busy_out stays 1 until the line returns to 1, no spurious frame.
- Overrun: ready_in=0, send 4'h1 then 4'h2 -> data_out stays 1, overrun_err pulses once; set ready_in=1 -> valid_out drops.
- Simultaneous accept and load: hold 4'h6 pending and assert ready_in on the stop-bit edge of 4'h9 -> no overrun, data_out=9, valid_out continuously 1.
- Reset mid-frame: assert rst after 2 data bits -> all outputs at reset values immediately; the next full frame 4'hF is received correctly.

Source files
------------

// File: rtl/serial_rx_pkg.sv
// Shared types and line-level constants for the single-wire serial frame protocol.
package serial_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_STOP,
    S_RECOVER
  } rx_state_t;

  localparam logic SERIAL_IDLE_LVL  = 1'b1;
  localparam logic SERIAL_START_LVL = 1'b0;
  localparam logic SERIAL_STOP_LVL  = 1'b1;

  localparam int unsigned SERIAL_DATA_W_DEF = 4;

endpackage

// File: rtl/serial_rx_sync2.sv
// Two-flop synchroniser for the serial line; both stages reset to the idle level
// so a reset never looks like a start bit.
module serial_sync2
  import serial_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= SERIAL_IDLE_LVL;
      q    <= SERIAL_IDLE_LVL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/serial_rx.sv
// Serial frame receiver: start bit, DATA_WIDTH bits LSB first, stop bit, one bit per clock.
// Define SERIAL_RX_SYNC_EN to insert a 2-flop synchroniser on serial_in (+2 cycles latency).
module serial_rx
  import serial_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = SERIAL_DATA_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  serial_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic                  busy_out,
  output logic                  frame_err,
  output logic                  overrun_err
);

  localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  logic                  line;
  rx_state_t             state;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [CNT_W-1:0]      bit_cnt;

`ifdef SERIAL_RX_SYNC_EN
  serial_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (serial_in),
    .q   (line)
  );
`else
  assign line = serial_in;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      shift_q     <= '0;
      bit_cnt     <= '0;
      data_out    <= '0;
      valid_out   <= 1'b0;
      busy_out    <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
      // A delivery below overrides this drop when both happen on the same edge.
      if (valid_out && ready_in) begin
        valid_out <= 1'b0;
      end
      case (state)
        S_IDLE: begin
          if (line == SERIAL_START_LVL) begin
            state    <= S_DATA;
            bit_cnt  <= '0;
            busy_out <= 1'b1;
          end
        end
        S_DATA: begin
          shift_q <= {line, shift_q[DATA_WIDTH-1:1]};
          bit_cnt <= bit_cnt + CNT_W'(1);
          if (bit_cnt == LAST_BIT) begin
            state <= S_STOP;
          end
        end
        S_STOP: begin
          if (line == SERIAL_STOP_LVL) begin
            state    <= S_IDLE;
            busy_out <= 1'b0;
            if (!valid_out || ready_in) begin
              data_out  <= shift_q;
              valid_out <= 1'b1;
            end else begin
              overrun_err <= 1'b1;
            end
          end else begin
            frame_err <= 1'b1;
            state     <= S_RECOVER;
          end
        end
        S_RECOVER: begin
          if (line == SERIAL_IDLE_LVL) begin
            state    <= S_IDLE;
            busy_out <= 1'b0;
          end
        end
        default: begin
          state    <= S_IDLE;
          busy_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_rx.sv
// Self-checking bench for serial_rx: frame-level stimulus plans with a timestamped
// event model of deliveries, framing errors and busy intervals.
module tb_serial_rx;

  localparam int W    = 4;
  localparam int MAXC = 600;
`ifdef SERIAL_RX_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         serial_in = 1'b1;
  logic         ready_in = 1'b0;
  logic [W-1:0] data_out;
  logic         valid_out;
  logic         busy_out;
  logic         frame_err;
  logic         overrun_err;

  serial_rx #(.DATA_WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .serial_in   (serial_in),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .ready_in    (ready_in),
    .busy_out    (busy_out),
    .frame_err   (frame_err),
    .overrun_err (overrun_err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Plan: per edge index, the line level, ready level, and the events the spec implies.
  bit           line_a [MAXC];
  bit           rdy_a  [MAXC];
  bit           busy_a [MAXC];
  bit           del_a  [MAXC];
  bit           ferr_a [MAXC];
  logic [W-1:0] word_a [MAXC];
  bit           lit_en [MAXC];
  bit           lit_v  [MAXC];
  logic [W-1:0] lit_d  [MAXC];
  bit           lit_ovr[MAXC];
  bit           lit_fe [MAXC];
  int           ncyc;

  bit           mv;
  logic [W-1:0] md;

  task automatic chk(input string name, input int n, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s edge %0d: got %0h expected %0h", name, n, act, exp);
    end
  endtask

  task automatic clear_plan();
    for (int i = 0; i < MAXC; i++) begin
      line_a[i] = 1'b1; rdy_a[i] = 1'b1; busy_a[i] = 1'b0; del_a[i] = 1'b0;
      ferr_a[i] = 1'b0; word_a[i] = '0; lit_en[i] = 1'b0; lit_v[i] = 1'b0;
      lit_d[i] = '0; lit_ovr[i] = 1'b0; lit_fe[i] = 1'b0;
    end
    ncyc = 0;
  endtask

  task automatic add_idle(input int k);
    for (int i = 0; i < k; i++) begin
      line_a[ncyc] = 1'b1; busy_a[ncyc] = 1'b0; ncyc++;
    end
  endtask

  task automatic add_head(input logic [W-1:0] w);
    line_a[ncyc] = 1'b0; busy_a[ncyc] = 1'b1; ncyc++;
    for (int i = 0; i < W; i++) begin
      line_a[ncyc] = w[i]; busy_a[ncyc] = 1'b1; ncyc++;
    end
  endtask

  task automatic add_good(input logic [W-1:0] w);
    add_head(w);
    line_a[ncyc] = 1'b1; busy_a[ncyc] = 1'b0; del_a[ncyc] = 1'b1; word_a[ncyc] = w; ncyc++;
  endtask

  task automatic add_bad(input logic [W-1:0] w, input int hold);
    add_head(w);
    line_a[ncyc] = 1'b0; busy_a[ncyc] = 1'b1; ferr_a[ncyc] = 1'b1; ncyc++;
    for (int i = 0; i < hold; i++) begin
      line_a[ncyc] = 1'b0; busy_a[ncyc] = 1'b1; ncyc++;
    end
    line_a[ncyc] = 1'b1; busy_a[ncyc] = 1'b0; ncyc++;
  endtask

  task automatic lit(input int m, input bit v, input logic [W-1:0] d, input bit ovr, input bit fe);
    lit_en[m] = 1'b1; lit_v[m] = v; lit_d[m] = d; lit_ovr[m] = ovr; lit_fe[m] = fe;
  endtask

  task automatic step(input int n);
    int  m;
    bit  e_fe, e_ovr, e_busy;
    m = n - LAT;
    @(negedge clk);
    serial_in = (n < MAXC) ? line_a[n] : 1'b1;
    ready_in  = (m >= 0) ? rdy_a[m] : 1'b1;
    @(posedge clk);
    #1;
    e_fe   = (m >= 0) && ferr_a[m];
    e_busy = (m >= 0) && busy_a[m];
    e_ovr  = 1'b0;
    if ((m >= 0) && del_a[m]) begin
      if (!mv || ready_in) begin
        md = word_a[m];
        mv = 1'b1;
      end else begin
        e_ovr = 1'b1;
      end
    end else if (mv && ready_in) begin
      mv = 1'b0;
    end
    chk("valid_out", n, int'(valid_out), int'(mv));
    chk("data_out", n, int'(data_out), int'(md));
    chk("busy_out", n, int'(busy_out), int'(e_busy));
    chk("frame_err", n, int'(frame_err), int'(e_fe));
    chk("overrun_err", n, int'(overrun_err), int'(e_ovr));
    if ((m >= 0) && lit_en[m]) begin
      chk("lit_valid", n, int'(valid_out), int'(lit_v[m]));
      chk("lit_data", n, int'(data_out), int'(lit_d[m]));
      chk("lit_overrun", n, int'(overrun_err), int'(lit_ovr[m]));
      chk("lit_frame_err", n, int'(frame_err), int'(lit_fe[m]));
    end
  endtask

  task automatic run_phase(input int limit);
    for (int n = 0; (n < limit) && (n < ncyc + LAT + 3); n++) begin
      step(n);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    serial_in = 1'b1;
    #1;
    chk("rst_valid", -1, int'(valid_out), 0);
    chk("rst_data", -1, int'(data_out), 0);
    chk("rst_busy", -1, int'(busy_out), 0);
    chk("rst_frame_err", -1, int'(frame_err), 0);
    chk("rst_overrun", -1, int'(overrun_err), 0);
    mv = 1'b0;
    md = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int r, bias;

    // Good frame 4'hA: line 1,0,0,1,0,1,1
    clear_plan();
    add_idle(1); add_good(4'hA); add_idle(2);
    lit(6, 1'b1, 4'hA, 1'b0, 1'b0);
    lit(7, 1'b0, 4'hA, 1'b0, 1'b0);
    do_reset();
    run_phase(MAXC);

    // Back-to-back 3 then C
    clear_plan();
    add_good(4'h3); add_good(4'hC); add_idle(2);
    lit(5, 1'b1, 4'h3, 1'b0, 1'b0);
    lit(6, 1'b0, 4'h3, 1'b0, 1'b0);
    lit(11, 1'b1, 4'hC, 1'b0, 1'b0);
    do_reset();
    run_phase(MAXC);

    // Framing error with the line held low 3 extra cycles
    clear_plan();
    add_bad(4'h5, 3); add_idle(3);
    lit(5, 1'b0, 4'h0, 1'b0, 1'b1);
    lit(6, 1'b0, 4'h0, 1'b0, 1'b0);
    do_reset();
    run_phase(MAXC);

    // Overrun: 1 then 2 with ready low, then ready high
    clear_plan();
    add_good(4'h1); add_good(4'h2); add_idle(4);
    for (int i = 0; i <= 12; i++) rdy_a[i] = 1'b0;
    lit(11, 1'b1, 4'h1, 1'b1, 1'b0);
    lit(12, 1'b1, 4'h1, 1'b0, 1'b0);
    lit(13, 1'b0, 4'h1, 1'b0, 1'b0);
    do_reset();
    run_phase(MAXC);

    // Accept and load on the same edge
    clear_plan();
    add_good(4'h6); add_good(4'h9); add_idle(3);
    for (int i = 0; i <= 10; i++) rdy_a[i] = 1'b0;
    lit(10, 1'b1, 4'h6, 1'b0, 1'b0);
    lit(11, 1'b1, 4'h9, 1'b0, 1'b0);
    lit(12, 1'b0, 4'h9, 1'b0, 1'b0);
    do_reset();
    run_phase(MAXC);

    // Reset after two data bits, then a clean 4'hF
    clear_plan();
    add_good(4'h7);
    do_reset();
    run_phase(3 + LAT);
    do_reset();
    clear_plan();
    add_good(4'hF); add_idle(2);
    lit(5, 1'b1, 4'hF, 1'b0, 1'b0);
    run_phase(MAXC);

    // Randomised frame mixes with varying consumer back-pressure
    for (int p = 0; p < 6; p++) begin
      clear_plan();
      while (ncyc < 450) begin
        r = $urandom_range(0, 9);
        if (r < 2)      add_idle($urandom_range(0, 3));
        else if (r < 8) add_good(W'($urandom));
        else            add_bad(W'($urandom), $urandom_range(0, 4));
      end
      bias = $urandom_range(1, 3);
      for (int i = 0; i < MAXC; i++) rdy_a[i] = ($urandom_range(0, 3) < bias);
      do_reset();
      run_phase(MAXC);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
